serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder that adds two parallel operands one bit per clock, LSB first, using a single full-adder cell built from two `Half_Adder` instances plus a registered carry. It sits directly downstream of the half-adder cell: it consumes the cell's `Sum`/`Carry` outputs every cycle and turns them into a multi-cycle, area-minimal N-bit addition with a start/done handshake.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥ 2)
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  operand A, captured on the accepting edge
- `b`  in  WIDTH  operand B, captured on the accepting edge
- `cin`  in  1  carry-in, captured on the accepting edge
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse, result valid
- `sum`  out  WIDTH  result, held until the next result is written
- `cout`  out  1  final carry, held with `sum`

## Operation
- FSM states:
  - IDLE → RUN on `start`=1.
  - RUN → DONE after WIDTH bit-steps.
  - DONE → IDLE unconditionally.
- Accept, at an IDLE edge with `start`=1:
  - load shift registers `ra`←`a`, `rb`←`b`, `sreg`←0
  - load carry register `c`←`cin` and bit counter←0
- RUN, each edge:
  - full-adder cell computes s = ra[0]^rb[0]^c and co = majority(ra[0], rb[0], c)
  - ra and rb shift right by 1; s shifts into sreg MSB (sreg right-shift); c←co; counter+1
  - on the step where counter = WIDTH-1: write `sum`←{s, sreg[WIDTH-1:1]} and `cout`←co, then go to DONE
- DONE: `done`=1 (Moore output) for exactly one cycle.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- `start` in RUN or DONE is ignored and not queued; an operand change after acceptance has no effect.
- `sum`/`cout` change only on the RUN→DONE edge. During a following operation they hold the previous result.
- Reset is asynchronous at any time, including mid-RUN:
  - state←IDLE
  - `busy`, `done`, `sum`, `cout`, counter, `c`, and all shift registers ←0
  - the aborted operation never produces `done`

## Timing
- Accepting edge t: `busy` rises after edge t.
- Bit k (0..WIDTH-1) is processed at edge t+1+k.
- `sum`/`cout` are valid and `done`=1 from edge t+WIDTH to edge t+WIDTH+1.
- `busy` falls after edge t+WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles; the earliest next accept is edge t+WIDTH+2.
- All outputs are registered; no combinational path from any input to any output.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.

## Structure
- Shared package/header `serial_adder_pkg`: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width function clog2(WIDTH).
- One sub-module, `Full_Adder_Cell`: two `Half_Adder` instances plus an OR of their carries. It is instantiated once in the datapath.
- Top level holds the FSM, counter, shift registers, carry flop and result registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → `busy`=0, `done`=0, `sum`=0x00, `cout`=0 throughout.
- WIDTH=8, `a`=0x5A, `b`=0x33, `cin`=0, one-cycle `start` → `done` pulses exactly 8 cycles after the accepting edge with `sum`=0x8D and `cout`=0. `busy` is high for 9 cycles.
- Carry-chain cases:
  - 0xFF+0x01, `cin`=0 → `sum`=0x00, `cout`=1
  - 0xFF+0xFF, `cin`=1 → `sum`=0xFF, `cout`=1
  - 0x00+0x00, `cin`=1 → `sum`=0x01, `cout`=0
- Handshake: hold `start`=1 continuously with `a`/`b` changing every cycle.
  - Each operation uses the operands present at its accepting edge only.
  - Accepts occur every 10 cycles.
  - `start` during DONE does not shorten the spacing.
  - `sum` holds the prior result until the next `done`.
- Reset mid-operation: start 0x12+0x34, then drop `rst_n` after 4 RUN edges → outputs go to 0 immediately and no `done` appears. Release reset and add 0x12+0x34 → `sum`=0x46, `cout`=0.
- Random regression: 1000 random {a, b, cin} → each `done` matches the reference a+b+cin. `done` is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// counter-width helper.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Smallest r with 2**r >= n; floors at 1 so the counter is never zero-width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half adders; the single arithmetic cell
// that the bit-serial adder reuses on every bit-step.
module Half_Adder (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B;
  assign Carry = A & B;

endmodule

module Full_Adder_Cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  Half_Adder ha0 (.A(a),  .B(b),   .Sum(s0),  .Carry(c0));
  Half_Adder ha1 (.A(s0), .B(cin), .Sum(sum), .Carry(c1));

  // Both half-adder carries can never be high together, so OR gives majority.
  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per
// clock, with a start/busy/done handshake and held result registers.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s;
  logic             co;

  Full_Adder_Cell fa (
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (c),
    .sum  (s),
    .cout (co)
  );

  // Partial sum shifts in from the top, so after WIDTH steps it is LSB-aligned.
  always_comb begin
    sreg_next = sreg >> 1;
    sreg_next[WIDTH-1] = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      sreg  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            sreg  <= '0;
            c     <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          ra   <= ra >> 1;
          rb   <= rb >> 1;
          sreg <= sreg_next;
          c    <= co;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= sreg_next;
            cout  <= co;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
